// File: rtl/div_ctrl_pkg.sv
// Shared types and sizing for the divider issue controller.
// Holds the FSM state encoding and the default widths and watchdog limit.
package div_ctrl_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_TAG_W   = 5;
    localparam int DIV_TIMEOUT = 40;
    localparam int DIV_CNT_W   = $clog2(DIV_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and
// for restoring the sign of the quotient.
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + {{(WIDTH-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue side of the iterative unsigned divider: accepts one op, handles sign
// and special cases, launches the divider, watches it, and returns the result.
module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int TAG_W   = DIV_TAG_W,
    parameter int TIMEOUT = DIV_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    input  logic             req_signed,
    input  logic [TAG_W-1:0] req_tag,
    output logic             stall,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_rdy,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic             div_exc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic             rsp_exc,
    output logic             rsp_timeout,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_dividend;
    logic [WIDTH-1:0]  r_divisor;
    logic [WIDTH-1:0]  r_quot;
    logic              r_neg_q;
    logic              r_exc;
    logic              r_timeout;
    logic [TAG_W-1:0]  r_tag;

    logic              w_sgn_a;
    logic              w_sgn_b;
    logic [WIDTH-1:0]  w_mag_a;
    logic [WIDTH-1:0]  w_mag_b;
    logic [WIDTH-1:0]  w_q_fix;
    logic              w_div_zero;
    logic              w_ovf;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_rdy_ok;

    assign w_sgn_a    = req_signed & req_dividend[WIDTH-1];
    assign w_sgn_b    = req_signed & req_divisor[WIDTH-1];
    assign w_div_zero = (req_divisor == '0);
    assign w_ovf      = req_signed && (req_dividend == MIN_NEG) && (req_divisor == '1);
    assign w_cnt_nxt  = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    // The first WAIT cycle may still see the flag left over from the previous op.
    assign w_rdy_ok   = div_rdy && (r_cnt != '0);

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_a (.i_val(req_dividend), .i_neg(w_sgn_a), .o_val(w_mag_a));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_b (.i_val(req_divisor),  .i_neg(w_sgn_b), .o_val(w_mag_b));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.i_val(div_quotient), .i_neg(r_neg_q), .o_val(w_q_fix));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_neg_q    <= 1'b0;
            r_exc      <= 1'b0;
            r_timeout  <= 1'b0;
            r_tag      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_tag      <= req_tag;
                        r_dividend <= w_mag_a;
                        r_divisor  <= w_mag_b;
                        r_neg_q    <= w_sgn_a ^ w_sgn_b;
                        r_timeout  <= 1'b0;
                        if (w_div_zero) begin
                            r_quot  <= '0;
                            r_exc   <= 1'b1;
                            r_state <= ST_RESP;
                        end else if (w_ovf) begin
                            r_quot  <= MIN_NEG;
                            r_exc   <= 1'b1;
                            r_state <= ST_RESP;
                        end else begin
                            r_exc   <= 1'b0;
                            r_state <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= w_cnt_nxt;
                    // A result arriving on the watchdog's last cycle still counts.
                    if (w_rdy_ok) begin
                        r_quot  <= w_q_fix;
                        r_exc   <= div_exc;
                        r_state <= ST_RESP;
                    end else if (w_cnt_nxt == CNT_W'(TIMEOUT)) begin
                        r_quot    <= '0;
                        r_exc     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = (r_state == ST_IDLE);
    assign stall        = (r_state != ST_IDLE);
    assign div_start    = (r_state == ST_LAUNCH);
    assign rsp_valid    = (r_state == ST_RESP);
    assign div_dividend = r_dividend;
    assign div_divisor  = r_divisor;
    assign rsp_quotient = r_quot;
    assign rsp_exc      = r_exc;
    assign rsp_timeout  = r_timeout;
    assign rsp_tag      = r_tag;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural unsigned divider that
// answers a fixed number of cycles after div_start.
module tb_div_issue_ctrl;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_dividend;
    logic [31:0] req_divisor;
    logic        req_signed;
    logic [4:0]  req_tag;
    logic        stall;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_rdy;
    logic [31:0] div_quotient;
    logic        div_exc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_quotient;
    logic        rsp_exc;
    logic        rsp_timeout;
    logic [4:0]  rsp_tag;

    int n_vec = 0;
    int n_bad = 0;

    // divider model
    int          lat = 34;
    logic        never_rdy = 1'b0;
    logic        stale_rdy = 1'b0;
    logic        m_busy;
    logic        m_rdy;
    int          m_cnt;
    logic [31:0] m_q;

    assign div_rdy      = m_rdy | stale_rdy;
    assign div_quotient = m_q;
    assign div_exc      = 1'b0;

    div_issue_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .req_signed(req_signed), .req_tag(req_tag),
        .stall(stall), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_rdy(div_rdy), .div_quotient(div_quotient), .div_exc(div_exc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_exc(rsp_exc),
        .rsp_timeout(rsp_timeout), .rsp_tag(rsp_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // m_rdy becomes visible `lat` cycles after the div_start cycle
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_rdy <= 1'b0;
            if (div_start) begin
                m_busy <= 1'b1;
                m_cnt  <= lat - 1;
                m_q    <= (div_divisor != 0) ? div_dividend / div_divisor : 32'hFFFF_FFFF;
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_rdy  <= !never_rdy;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [4:0] t);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_dividend = a; req_divisor = b; req_signed = s; req_tag = t;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // i = 0 is the first cycle after the accept edge
    task automatic run_op(input int clear_stale_at, output int starts, output int rdy_i,
                          output int resp_i, output logic rr_seen);
        starts = 0; rdy_i = -1; resp_i = -1; rr_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == clear_stale_at) stale_rdy = 1'b0;
            if (div_start) starts++;
            if (req_ready) rr_seen = 1'b1;
            if (m_rdy) rdy_i = i;
            if (rsp_valid) begin
                resp_i = i;
                break;
            end
            @(negedge clock);
        end
        if (resp_i < 0) chk("rsp_wait_bound", 64'd0, 64'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        chk("stall_drop", 64'(stall), 64'd0);
        chk("req_ready_back", 64'(req_ready), 64'd1);
    endtask

    initial begin
        int st, ri, pi;
        logic rr;
        logic [31:0] q0;

        reset = 1'b1; req_valid = 1'b0; req_dividend = '0; req_divisor = '0;
        req_signed = 1'b0; req_tag = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_div_start", 64'(div_start), 64'd0);
        chk("rst_div_dividend", 64'(div_dividend), 64'd0);
        chk("rst_rsp_quot", 64'(rsp_quotient), 64'd0);
        chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // 1: unsigned 6480321 / 746
        issue(32'd6480321, 32'd746, 1'b0, 5'd3);
        chk("t1_stall", 64'(stall), 64'd1);
        run_op(-1, st, ri, pi, rr);
        chk("t1_starts", 64'(st), 64'd1);
        chk("t1_rdy_cycle", 64'(ri), 64'd34);
        chk("t1_resp_cycle", 64'(pi), 64'd35);
        chk("t1_quot", 64'(rsp_quotient), 64'd8686);
        chk("t1_exc", 64'(rsp_exc), 64'd0);
        chk("t1_timeout", 64'(rsp_timeout), 64'd0);
        chk("t1_tag", 64'(rsp_tag), 64'd3);
        chk("t1_req_ready", 64'(rr), 64'd0);
        handshake();

        // 2: signed -500 / 3
        issue(32'hFFFF_FE0C, 32'd3, 1'b1, 5'd17);
        run_op(-1, st, ri, pi, rr);
        chk("t2_div_dividend", 64'(div_dividend), 64'd500);
        chk("t2_div_divisor", 64'(div_divisor), 64'd3);
        chk("t2_starts", 64'(st), 64'd1);
        chk("t2_quot", 64'(rsp_quotient), 64'hFFFF_FF5A);
        chk("t2_exc", 64'(rsp_exc), 64'd0);
        chk("t2_tag", 64'(rsp_tag), 64'd17);
        handshake();

        // 3: divide by zero
        issue(32'd50, 32'd0, 1'b0, 5'd9);
        run_op(-1, st, ri, pi, rr);
        chk("t3_starts", 64'(st), 64'd0);
        chk("t3_resp_cycle", 64'(pi), 64'd0);
        chk("t3_quot", 64'(rsp_quotient), 64'd0);
        chk("t3_exc", 64'(rsp_exc), 64'd1);
        chk("t3_stall", 64'(stall), 64'd1);
        chk("t3_tag", 64'(rsp_tag), 64'd9);
        handshake();

        // 4: signed overflow
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd31);
        run_op(-1, st, ri, pi, rr);
        chk("t4_starts", 64'(st), 64'd0);
        chk("t4_resp_cycle", 64'(pi), 64'd0);
        chk("t4_quot", 64'(rsp_quotient), 64'h8000_0000);
        chk("t4_exc", 64'(rsp_exc), 64'd1);
        handshake();

        // 5: watchdog, response held while writeback stalls
        never_rdy = 1'b1;
        issue(32'd1000, 32'd10, 1'b0, 5'd5);
        run_op(-1, st, ri, pi, rr);
        chk("t5_resp_cycle", 64'(pi), 64'd41);
        chk("t5_timeout", 64'(rsp_timeout), 64'd1);
        chk("t5_exc", 64'(rsp_exc), 64'd1);
        chk("t5_quot", 64'(rsp_quotient), 64'd0);
        chk("t5_req_ready", 64'(rr), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("t5_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t5_hold_timeout", 64'(rsp_timeout), 64'd1);
            chk("t5_hold_quot", 64'(rsp_quotient), 64'd0);
            chk("t5_hold_tag", 64'(rsp_tag), 64'd5);
            chk("t5_hold_req_ready", 64'(req_ready), 64'd0);
        end
        handshake();
        never_rdy = 1'b0;

        // 6: reset mid-WAIT, then a stale div_rdy must not complete the next op
        issue(32'd100, 32'd7, 1'b0, 5'd6);
        repeat (5) @(negedge clock);
        chk("t6_busy", 64'(stall), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_stall", 64'(stall), 64'd0);
        chk("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        stale_rdy = 1'b1;
        @(negedge clock);
        chk("t6_idle_rsp_valid", 64'(rsp_valid), 64'd0);
        issue(32'd32, 32'd8, 1'b0, 5'd12);
        run_op(2, st, ri, pi, rr);
        chk("t6_starts", 64'(st), 64'd1);
        chk("t6_resp_cycle", 64'(pi), 64'd35);
        chk("t6_quot", 64'(rsp_quotient), 64'd4);
        chk("t6_tag", 64'(rsp_tag), 64'd12);
        q0 = rsp_quotient;
        handshake();
        chk("t6_quot_kept", 64'(rsp_quotient), 64'(q0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
